// File: rtl/sysarr_defs.sv
// Shared definitions for the 3x3 half-precision systolic array family.
// Holds array geometry, binary16 field positions, the collector state
// encoding and the fixed capture latency of the array.
package sysarr_defs;

  localparam int SA_DIM     = 3;
  localparam int SA_ELEMS   = SA_DIM * SA_DIM;
  localparam int HP_W       = 16;
  localparam int HP_EXP_MSB = 14;
  localparam int HP_EXP_LSB = 10;
  localparam int SA_CAP0    = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAP,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/hp_exc_detect.sv
// Binary16 exception detector.
// Flags a word whose exponent field is all ones (Inf or NaN).
// Ports:
//   word - binary16 input word
//   exc  - 1 when the exponent field is all ones
module hp_exc_detect
  import sysarr_defs::*;
#(
  parameter int W       = HP_W,
  parameter int EXP_MSB = HP_EXP_MSB,
  parameter int EXP_LSB = HP_EXP_LSB
) (
  input  logic [W-1:0] word,
  output logic         exc
);

  always_comb begin
    exc = &word[EXP_MSB:EXP_LSB];
  end

endmodule

// File: rtl/sysarr_result_collector.sv
// Result collector for the 3x3 binary16 systolic array.
// Captures the five diagonal result ports over three fixed-latency cycles
// after a start pulse, then streams the nine words row-major over a
// valid/ready handshake.
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   start                     - 1-cycle pulse aligned with array input wave 0
//   c53,c54,c55 / c35,c45     - array bottom / right edge diagonal outputs
//   res_data,res_idx          - result word and its row*3+col index
//   res_exc                   - result word is Inf/NaN
//   res_last                  - current beat is index 8
//   res_valid / res_ready     - output handshake
//   busy                      - job in progress (any state but idle)
//   start_err                 - 1-cycle pulse when a start arrives while busy
module sysarr_result_collector
  import sysarr_defs::*;
#(
  parameter int N    = 15,
  parameter int CAP0 = SA_CAP0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [N:0] c53,
  input  logic [N:0] c54,
  input  logic [N:0] c55,
  input  logic [N:0] c35,
  input  logic [N:0] c45,
  output logic [N:0] res_data,
  output logic [3:0] res_idx,
  output logic       res_exc,
  output logic       res_last,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy,
  output logic       start_err
);

  state_t     state;
  logic [2:0] cnt;
  logic [1:0] kcnt;
  logic [3:0] idx_nxt;

  // Row-major flat storage: element r*3+c holds d[r][c].
  logic [N:0] mat [SA_ELEMS];

  always_comb begin
    idx_nxt = res_idx + 4'd1;
    busy    = (state != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      kcnt      <= '0;
      res_data  <= '0;
      res_idx   <= '0;
      res_last  <= 1'b0;
      res_valid <= 1'b0;
      start_err <= 1'b0;
      for (int unsigned i = 0; i < SA_ELEMS; i++) begin
        mat[i] <= '0;
      end
    end else begin
      // Any start outside IDLE is dropped and reported, including one that
      // coincides with the final drain transfer.
      start_err <= start && (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_WAIT;
            cnt   <= 3'(CAP0 - 1);
          end
        end

        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_CAP;
            kcnt  <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        ST_CAP: begin
          kcnt <= kcnt + 2'd1;
          case (kcnt)
            2'd0: begin
              mat[0] <= c55;
              mat[1] <= c45;
              mat[2] <= c35;
              mat[3] <= c54;
              mat[6] <= c53;
            end
            2'd1: begin
              mat[4] <= c55;
              mat[5] <= c45;
              mat[7] <= c54;
            end
            default: begin
              // d00 was captured two edges ago, so the first beat can be
              // preloaded while d22 is still being written.
              mat[8]    <= c55;
              state     <= ST_DRAIN;
              res_valid <= 1'b1;
              res_idx   <= '0;
              res_data  <= mat[0];
              res_last  <= 1'b0;
            end
          endcase
        end

        ST_DRAIN: begin
          if (res_ready) begin
            if (res_idx == 4'd8) begin
              state     <= ST_IDLE;
              res_valid <= 1'b0;
              res_last  <= 1'b0;
            end else begin
              res_idx  <= idx_nxt;
              res_data <= mat[idx_nxt];
              res_last <= (idx_nxt == 4'd8);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  hp_exc_detect #(
    .W       (N + 1),
    .EXP_MSB (HP_EXP_MSB),
    .EXP_LSB (HP_EXP_LSB)
  ) u_exc (
    .word (res_data),
    .exc  (res_exc)
  );

endmodule
